// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard inputs from ID/EX/MEM and pipeline register enable/flush controls
interface pipeline_hazard_ctrl_if;
    logic [4:0] rs1_ID;
    logic [4:0] rs2_ID;
    logic [4:0] rd_EX;
    logic       mem_read_EX;
    logic       is_mul_EX;
    logic       redirect_MEM;
    logic       pc_en;
    logic       if_id_en;
    logic       id_ex_en;
    logic       ex_mem_en;
    logic       mem_wb_en;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       ex_mem_flush;

    modport master (
        output rs1_ID, rs2_ID, rd_EX, mem_read_EX, is_mul_EX, redirect_MEM,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        input  if_id_flush, id_ex_flush, ex_mem_flush
    );

    modport slave (
        input  rs1_ID, rs2_ID, rd_EX, mem_read_EX, is_mul_EX, redirect_MEM,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        output if_id_flush, id_ex_flush, ex_mem_flush
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - 5-stage pipeline hazard FSM: redirect flush, multi-cycle multiply, load-use stall
module pipeline_hazard_ctrl #(
    parameter int MUL_LAT = 3,
    parameter int CNT_W   = 32
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  enable,
    pipeline_hazard_ctrl_if.slave hz,
    output logic [1:0]            state,
    output logic [CNT_W-1:0]      stall_cycles
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_MUL  = 2'd2
    } state_t;

    localparam logic [2:0] MUL_INIT = (MUL_LAT > 1) ? 3'(MUL_LAT - 2) : 3'd0;
    localparam bit         MUL_ON   = (MUL_LAT > 1);

    state_t     st;
    logic [2:0] cnt;
    logic       mul_start;
    logic       load_use;
    logic       stall_inc;

    assign state = st;

    always_comb begin
        load_use  = hz.mem_read_EX && (hz.rd_EX != 5'd0) &&
                    ((hz.rd_EX == hz.rs1_ID) || (hz.rd_EX == hz.rs2_ID));
        mul_start = MUL_ON && hz.is_mul_EX && !hz.redirect_MEM;
    end

    always_comb begin
        hz.pc_en        = 1'b0;
        hz.if_id_en     = 1'b0;
        hz.id_ex_en     = 1'b0;
        hz.ex_mem_en    = 1'b0;
        hz.mem_wb_en    = 1'b0;
        hz.if_id_flush  = 1'b0;
        hz.id_ex_flush  = 1'b0;
        hz.ex_mem_flush = 1'b0;
        if (enable && st != ST_IDLE) begin
            // Multiply stall: hold front end, push bubbles into MEM while EX is busy
            if ((st == ST_RUN && !hz.redirect_MEM && mul_start) ||
                (st == ST_MUL && cnt != 3'd0)) begin
                hz.ex_mem_en    = 1'b1;
                hz.ex_mem_flush = 1'b1;
                hz.mem_wb_en    = 1'b1;
            end else if (st == ST_RUN && !hz.redirect_MEM && load_use) begin
                hz.id_ex_en    = 1'b1;
                hz.id_ex_flush = 1'b1;
                hz.ex_mem_en   = 1'b1;
                hz.mem_wb_en   = 1'b1;
            end else begin
                hz.pc_en     = 1'b1;
                hz.if_id_en  = 1'b1;
                hz.id_ex_en  = 1'b1;
                hz.ex_mem_en = 1'b1;
                hz.mem_wb_en = 1'b1;
                if (st == ST_RUN && hz.redirect_MEM) begin
                    hz.if_id_flush  = 1'b1;
                    hz.id_ex_flush  = 1'b1;
                    hz.ex_mem_flush = 1'b1;
                end
            end
        end
    end

    assign stall_inc = enable && (st != ST_IDLE) && !hz.pc_en;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            st           <= ST_IDLE;
            cnt          <= 3'd0;
            stall_cycles <= '0;
        end else begin
            if (stall_inc && stall_cycles != {CNT_W{1'b1}})
                stall_cycles <= stall_cycles + CNT_W'(1);
            case (st)
                ST_IDLE: begin
                    if (enable)
                        st <= ST_RUN;
                end
                ST_RUN: begin
                    if (!enable) begin
                        st  <= ST_IDLE;
                        cnt <= 3'd0;
                    end else if (mul_start) begin
                        st  <= ST_MUL;
                        cnt <= MUL_INIT;
                    end
                end
                ST_MUL: begin
                    // Dropping enable aborts the multiply; it restarts from scratch later
                    if (!enable) begin
                        st  <= ST_IDLE;
                        cnt <= 3'd0;
                    end else if (cnt == 3'd0) begin
                        st <= ST_RUN;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: begin
                    st  <= ST_IDLE;
                    cnt <= 3'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for pipeline_hazard_ctrl (MUL_LAT=3, CNT_W=4)
module tb_pipeline_hazard_ctrl;
    localparam int MUL_LAT = 3;
    localparam int CNT_W   = 4;

    typedef struct {
        string      tag;
        logic [7:0] outs;
        logic [1:0] st;
        logic [3:0] stall;
    } exp_t;

    logic clk = 1'b0;
    logic arst_n;
    logic enable;
    logic [1:0] state;
    logic [CNT_W-1:0] stall_cycles;

    pipeline_hazard_ctrl_if hz ();

    pipeline_hazard_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .enable       (enable),
        .hz           (hz.slave),
        .state        (state),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    exp_t sb[$];

    int m_state;
    int m_cnt;
    int m_stall;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] dut_outs();
        return {hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.ex_mem_en, hz.mem_wb_en,
                hz.if_id_flush, hz.id_ex_flush, hz.ex_mem_flush};
    endfunction

    // bit order: pc, if_id, id_ex, ex_mem, mem_wb, f_if_id, f_id_ex, f_ex_mem
    function automatic logic [7:0] model_outs(input logic en, input logic lu,
                                              input logic mul, input logic redir);
        if (!en || m_state == 0) return 8'b00000_000;
        if (m_state == 2) return (m_cnt != 0) ? 8'b00011_001 : 8'b11111_000;
        if (redir) return 8'b11111_111;
        if (mul)   return 8'b00011_001;
        if (lu)    return 8'b00111_010;
        return 8'b11111_000;
    endfunction

    task automatic step(input string tag, input logic en, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [4:0] rd, input logic mr,
                        input logic mul, input logic redir);
        exp_t e, o;
        logic lu;
        logic [7:0] eo;
        enable = en; hz.rs1_ID = r1; hz.rs2_ID = r2; hz.rd_EX = rd;
        hz.mem_read_EX = mr; hz.is_mul_EX = mul; hz.redirect_MEM = redir;
        lu = mr && rd != 0 && (rd == r1 || rd == r2);
        eo = model_outs(en, lu, mul, redir);
        e.tag = tag; e.outs = eo; e.st = 2'(m_state); e.stall = 4'(m_stall);
        sb.push_back(e);
        @(negedge clk);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            o = sb.pop_front();
            check({o.tag, "_outs"},  32'(dut_outs()),   32'(o.outs));
            check({o.tag, "_state"}, 32'(state),        32'(o.st));
            check({o.tag, "_stall"}, 32'(stall_cycles), 32'(o.stall));
        end
        if (en && m_state != 0 && eo[7] == 1'b0 && m_stall < 15) m_stall++;
        case (m_state)
            0: if (en) m_state = 1;
            1: if (!en) begin m_state = 0; m_cnt = 0; end
               else if (mul && !redir) begin m_state = 2; m_cnt = MUL_LAT - 2; end
            default: if (!en) begin m_state = 0; m_cnt = 0; end
                     else if (m_cnt == 0) m_state = 1;
                     else m_cnt--;
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        enable = 1'b0; hz.rs1_ID = 5'd0; hz.rs2_ID = 5'd0; hz.rd_EX = 5'd0;
        hz.mem_read_EX = 1'b0; hz.is_mul_EX = 1'b0; hz.redirect_MEM = 1'b0;
    endtask

    initial begin
        m_state = 0; m_cnt = 0; m_stall = 0;
        arst_n = 1'b0;
        idle_inputs();
        enable = 1'b1;
        hz.mem_read_EX = 1'b1; hz.rd_EX = 5'd3; hz.rs1_ID = 5'd3; hz.redirect_MEM = 1'b1;
        #3;
        check("reset_outs",  32'(dut_outs()),   32'd0);
        check("reset_state", 32'(state),        32'd0);
        check("reset_stall", 32'(stall_cycles), 32'd0);
        idle_inputs();
        #9 arst_n = 1'b1;
        @(posedge clk); #1;

        step("start_idle",  1, 0, 0, 0, 0, 0, 0);
        step("run_default", 1, 1, 2, 3, 0, 0, 0);

        step("mul_c0", 1, 0, 0, 0, 0, 1, 0);
        step("mul_c1", 1, 0, 0, 0, 0, 1, 0);
        step("mul_c2", 1, 0, 0, 0, 0, 1, 0);
        check("mul_stall_total", 32'(stall_cycles), 32'd2);
        step("mul_back2back", 1, 0, 0, 0, 0, 0, 0);

        step("lu_rs2",      1, 7, 5, 5, 1, 0, 0);
        step("lu_after",    1, 7, 5, 6, 1, 0, 0);
        step("lu_rd0",      1, 0, 0, 0, 1, 0, 0);
        step("lu_rs1",      1, 9, 1, 9, 1, 0, 0);
        step("lu_noload",   1, 9, 1, 9, 0, 0, 0);

        step("redir_all",   1, 4, 4, 4, 1, 1, 1);
        step("redir_after", 1, 0, 0, 0, 0, 0, 0);

        step("ab_mul0",   1, 0, 0, 0, 0, 1, 0);
        step("ab_drop",   0, 0, 0, 0, 0, 1, 0);
        step("ab_idle",   1, 0, 0, 0, 0, 1, 0);
        step("ab_mul_r",  1, 0, 0, 0, 0, 1, 0);
        step("ab_mul_m1", 1, 0, 0, 0, 0, 1, 0);
        step("ab_mul_m0", 1, 0, 0, 0, 0, 0, 1);
        step("ab_run",    1, 0, 0, 0, 0, 0, 0);
        step("run_drop",  0, 0, 0, 0, 0, 0, 0);
        step("run_idle",  1, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 20; i++)
            step($sformatf("sat_%0d", i), 1, 8, 2, 8, 1, 0, 0);
        check("sat_final", 32'(stall_cycles), 32'd15);

        step("pre_rst_mul", 1, 0, 0, 0, 0, 1, 0);
        arst_n = 1'b0;
        #2;
        check("arst_state", 32'(state),        32'd0);
        check("arst_stall", 32'(stall_cycles), 32'd0);
        check("arst_outs",  32'(dut_outs()),   32'd0);
        m_state = 0; m_cnt = 0; m_stall = 0;
        idle_inputs();
        #1 arst_n = 1'b1;
        @(posedge clk); #1;
        step("post_idle", 1, 0, 0, 0, 0, 0, 0);
        step("post_mul0", 1, 0, 0, 0, 0, 1, 0);
        step("post_mul1", 1, 0, 0, 0, 0, 0, 0);
        step("post_mul2", 1, 0, 0, 0, 0, 0, 0);
        step("post_run",  1, 0, 0, 0, 0, 0, 0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1);
    end
endmodule
